// File: rtl/dsp_product_reader.sv
// Snapshots N_PROD 64-bit products after a settle delay and streams them as a byte frame.
// Optional trailing XOR checksum byte: define DSP_READER_CHECKSUM_EN.
module dsp_product_reader #(
  parameter int unsigned N_PROD        = 5,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [64*N_PROD-1:0]  products,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_HEADER  = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
`ifdef DSP_READER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd5;
`endif
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [6:0] LAST_BYTE = 7'(8 * N_PROD - 1);
  localparam logic [7:0] HEADER    = 8'hA5;

  logic [2:0]            r_state;
  logic [7:0]            r_settle_cnt;
  logic [6:0]            r_byte_cnt;
  // Snapshot shifts right one byte per DATA transfer, so bits [7:0] are always the next byte.
  logic [64*N_PROD-1:0]  r_snap;
`ifdef DSP_READER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif
  logic                  w_xfer;

  assign w_xfer = tx_valid & tx_ready;

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = r_snap[7:0];
      end
`ifdef DSP_READER_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = r_csum;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= 8'd0;
      r_byte_cnt   <= 7'd0;
      r_snap       <= '0;
`ifdef DSP_READER_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= 8'(SETTLE_CYCLES - 1);
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == 8'd0) r_state <= S_CAPTURE;
          else                      r_settle_cnt <= r_settle_cnt - 8'd1;
        end
        S_CAPTURE: begin
          r_snap     <= products;
          r_byte_cnt <= 7'd0;
`ifdef DSP_READER_CHECKSUM_EN
          r_csum     <= 8'h00;
`endif
          r_state    <= S_HEADER;
        end
        S_HEADER: begin
          if (w_xfer) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_xfer) begin
            r_snap <= r_snap >> 8;
`ifdef DSP_READER_CHECKSUM_EN
            r_csum <= r_csum ^ tx_data;
`endif
            if (r_byte_cnt == LAST_BYTE) begin
              r_byte_cnt <= 7'd0;
`ifdef DSP_READER_CHECKSUM_EN
              r_state    <= S_CSUM;
`else
              r_state    <= S_DONE;
`endif
            end else begin
              r_byte_cnt <= r_byte_cnt + 7'd1;
            end
          end
        end
`ifdef DSP_READER_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer) r_state <= S_DONE;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_product_reader.sv
// Directed, table-driven bench for dsp_product_reader (default and checksum builds).
module tb_dsp_product_reader;

  localparam int NP = 5;
  localparam int SC = 8;
`ifdef DSP_READER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              tx_ready = 1'b0;
  logic [64*NP-1:0]  products = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  dsp_product_reader #(
    .N_PROD        (NP),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .products (products),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [63:0] p [NP];
    logic [7:0]  csum;
    int          rmode;
    bit          snap;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         ready_mode = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  vec_t       vecs [5];

  // Transfers are sampled on the falling edge; they complete on the following rising edge.
  always @(negedge clk) begin
    if (!reset && prev_stall) begin
      checks++;
      if (!tx_valid || tx_data !== prev_data) begin
        errors++;
        $display("FAIL hold: valid=%0b data=%02h, required valid=1 data=%02h",
                 tx_valid, tx_data, prev_data);
      end
    end
    prev_stall = tx_valid && !tx_ready && !reset;
    prev_data  = tx_data;
    if (tx_valid && tx_ready && !reset) rx_q.push_back(tx_data);
    if (done && !reset) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
  endtask

  task automatic load(input vec_t v);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NP; k++) begin
      products[64*k +: 64] = v.p[k];
      for (int b = 0; b < 8; b++) exp_q.push_back(v.p[k][8*b +: 8]);
    end
    if (CS != 0) exp_q.push_back(v.csum);
    rx_q.delete();
  endtask

  task automatic compare_frame(input string name);
    check({name, " length"}, 64'(rx_q.size()), 64'(1 + 8*NP + CS));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check($sformatf("%s byte%0d", name, i), {56'd0, rx_q[i]}, {56'd0, exp_q[i]});
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check({name, " done seen"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int lat = 0;
    int d0;
    load(v);
    ready_mode = v.rmode;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!tx_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(SC + 1));
    if (v.snap) products = '1;
    wait_done(name);
    tick();
    check({name, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, " idle after"}, {63'd0, busy}, 64'd0);
    compare_frame(name);
  endtask

  initial begin
    logic [7:0] hand [9];
    int n;
    int d0;
    hand = '{8'hA5, 8'h31, 8'hDB, 8'h1F, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

    vecs[0].p = '{64'h11FDB31, 64'h4, 64'h10, 64'h14, 64'h18};
    vecs[0].csum = 8'hEC; vecs[0].rmode = 0; vecs[0].snap = 1'b0;
    vecs[1] = vecs[0]; vecs[1].rmode = 1;
    vecs[2] = vecs[0]; vecs[2].snap = 1'b1;
    vecs[3].p = '{64'h5A, 64'h0, 64'h0, 64'h0, 64'hFF00_0000_0000_0080};
    vecs[3].csum = 8'h25; vecs[3].rmode = 0; vecs[3].snap = 1'b0;
    vecs[4].p = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[4].csum = 8'h00; vecs[4].rmode = 1; vecs[4].snap = 1'b0;

    reset = 1'b1;
    products = '1;
    repeat (3) tick();
    check("reset tx_valid", {63'd0, tx_valid}, 64'd0);
    check("reset tx_data", {56'd0, tx_data}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Literal frame prefix for the reference product set.
    load(vecs[0]);
    ready_mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    wait_done("literal"); tick();
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) check($sformatf("literal byte%0d", i), {56'd0, rx_q[i]}, {56'd0, hand[i]});
    end
    if (CS != 0 && rx_q.size() == 42) check("literal csum", {56'd0, rx_q[41]}, 64'hEC);

    // Abort after the 10th transfer, then a clean frame.
    load(vecs[0]);
    ready_mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (rx_q.size() < 10 && n < 200) begin
      tick();
      n++;
    end
    reset = 1'b1;
    repeat (3) tick();
    check("abort bytes", 64'(rx_q.size()), 64'd10);
    check("abort tx_valid", {63'd0, tx_valid}, 64'd0);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort tx_data", {56'd0, tx_data}, 64'd0);
    reset = 1'b0;
    tick();
    run_frame(vecs[0], "post-abort");

    // Start held high: one frame per IDLE visit, one idle cycle between frames.
    load(vecs[0]);
    ready_mode = 0;
    d0 = done_cnt;
    start = 1'b1;
    wait_done("held");
    tick();
    check("held gap busy", {63'd0, busy}, 64'd0);
    tick();
    check("held restart busy", {63'd0, busy}, 64'd1);
    start = 1'b0;
    check("held done pulses", 64'(done_cnt - d0), 64'd1);
    compare_frame("held");
    wait_done("held drain");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
